// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4-column x 5-row active-low matrix keypad, debounces
// presses and releases, and emits a one-cycle newkey pulse with a 5-bit keycode.
//
// Ports:
//   clock   - system clock, rising edge
//   reset   - synchronous, active-high
//   row_n   - keypad rows, active-low, asynchronous (synchronised internally)
//   col_n   - column drive, active-low, exactly one bit low
//   newkey  - one-cycle pulse per accepted press
//   keycode - code of the last accepted key (0-F hex, 10000..10011 = + - x =)
module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] row_n,
  output logic [3:0] col_n,
  output logic       newkey,
  output logic [4:0] keycode
);

  localparam int unsigned CntW   = $clog2(SCAN_DIV);
  localparam int unsigned MatchW = $clog2(DEBOUNCE + 1);
  localparam logic [CntW-1:0]   CntMax   = CntW'(SCAN_DIV - 1);
  localparam logic [MatchW-1:0] MatchMax = MatchW'(DEBOUNCE);

  typedef enum logic [1:0] {StScan, StDebounce, StHeld} state_e;

  state_e            state_q, state_d;
  logic [4:0]        sync_q, rs_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        col_q, col_d;
  logic [2:0]        row_q, row_d;
  logic [MatchW-1:0] match_q, match_d, rel_q, rel_d;
  logic              newkey_q, newkey_d;
  logic [4:0]        keycode_q, keycode_d;

  logic              sample;
  logic              any_low;
  logic [2:0]        win_row;
  logic [MatchW-1:0] match_inc, rel_inc;
  logic [4:0]        code;

  assign sample    = (cnt_q == CntMax);
  assign match_inc = match_q + MatchW'(1);
  assign rel_inc   = rel_q + MatchW'(1);

  // Descending scan so the lowest low row is the one left in win_row.
  always_comb begin
    any_low = 1'b0;
    win_row = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (!rs_q[i]) begin
        any_low = 1'b1;
        win_row = 3'(i);
      end
    end
  end

  // Row 4 holds the operator keys (k = 16..19); other rows map to hex digits.
  assign code = (row_q == 3'd4) ? {3'b100, col_q} : {1'b0, row_q[1:0], col_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = sample ? '0 : cnt_q + CntW'(1);
    col_d     = col_q;
    row_d     = row_q;
    match_d   = match_q;
    rel_d     = rel_q;
    newkey_d  = 1'b0;
    keycode_d = keycode_q;

    case (state_q)
      StScan: begin
        if (sample) begin
          if (any_low) begin
            row_d   = win_row;
            match_d = MatchW'(1);
            state_d = StDebounce;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      StDebounce: begin
        if (sample) begin
          if (any_low && (win_row == row_q)) begin
            match_d = match_inc;
            if (match_inc == MatchMax) begin
              state_d   = StHeld;
              newkey_d  = 1'b1;
              keycode_d = code;
              rel_d     = '0;
            end
          end else begin
            state_d = StScan;
            col_d   = col_q + 2'd1;
            match_d = '0;
          end
        end
      end
      StHeld: begin
        if (sample) begin
          if (any_low) begin
            rel_d = '0;
          end else if (rel_inc == MatchMax) begin
            // Resume scanning on the same column; cnt_d is already 0 here.
            state_d = StScan;
            rel_d   = '0;
            match_d = '0;
          end else begin
            rel_d = rel_inc;
          end
        end
      end
      default: state_d = StScan;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StScan;
      sync_q    <= '1;
      rs_q      <= '1;
      cnt_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      match_q   <= '0;
      rel_q     <= '0;
      newkey_q  <= 1'b0;
      keycode_q <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= row_n;
      rs_q      <= sync_q;
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      row_q     <= row_d;
      match_q   <= match_d;
      rel_q     <= rel_d;
      newkey_q  <= newkey_d;
      keycode_q <= keycode_d;
    end
  end

  assign col_n   = ~(4'b0001 << col_q);
  assign newkey  = newkey_q;
  assign keycode = keycode_q;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] row_n;
  logic [3:0] col_n;
  logic       newkey;
  logic [4:0] keycode;

  // One bit per key, index k = row*4 + col.
  logic [19:0] keys = '0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulses = 0;
  int last_cyc = -1;
  logic [4:0] last_code = '0;

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE(3)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .row_n  (row_n),
    .col_n  (col_n),
    .newkey (newkey),
    .keycode(keycode)
  );

  always #5 clock = ~clock;

  // Passive keypad matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_n = '1;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
      end
    end
  end

  // Cycle 0 is the first cycle with reset low.
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge clock) begin
    if (newkey) begin
      pulses    <= pulses + 1;
      last_cyc  <= cyc;
      last_code <= keycode;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    do @(negedge clock); while (cyc < n);
  endtask

  task automatic test_reset();
    keys = '0;
    do_reset();
    wait_cyc(0);
    checks++; if (col_n !== 4'b1110) begin errors++; $display("FAIL reset_col_n: got %b want 1110", col_n); end
    checks++; if (newkey !== 1'b0) begin errors++; $display("FAIL reset_newkey: got %b want 0", newkey); end
    checks++; if (keycode !== 5'b00000) begin errors++; $display("FAIL reset_keycode: got %b want 00000", keycode); end
    wait_cyc(3);
    checks++; if (col_n !== 4'b1110) begin errors++; $display("FAIL idle_col_c3: got %b want 1110", col_n); end
    wait_cyc(4);
    checks++; if (col_n !== 4'b1101) begin errors++; $display("FAIL idle_col_c4: got %b want 1101", col_n); end
    wait_cyc(16);
    checks++; if (col_n !== 4'b1110) begin errors++; $display("FAIL idle_col_c16: got %b want 1110", col_n); end
  endtask

  task automatic test_basic();
    int p0;
    keys = 20'h00001;
    do_reset();
    p0 = pulses;
    wait_cyc(11);
    checks++; if (newkey !== 1'b0) begin errors++; $display("FAIL basic_c11: newkey %b want 0", newkey); end
    wait_cyc(12);
    checks++; if (newkey !== 1'b1) begin errors++; $display("FAIL basic_c12: newkey %b want 1", newkey); end
    checks++; if (keycode !== 5'b00000) begin errors++; $display("FAIL basic_code: got %b want 00000", keycode); end
    wait_cyc(13);
    checks++; if (newkey !== 1'b0) begin errors++; $display("FAIL basic_c13: newkey %b want 0", newkey); end
    wait_cyc(212);
    checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL basic_held: pulses %0d want 1", pulses - p0); end
  endtask

  task automatic test_operator();
    int p0;
    keys = 20'h80000;
    do_reset();
    p0 = pulses;
    wait_cyc(11);
    checks++; if (col_n !== 4'b1011) begin errors++; $display("FAIL op_col_c11: got %b want 1011", col_n); end
    wait_cyc(12);
    checks++; if (col_n !== 4'b0111) begin errors++; $display("FAIL op_col_c12: got %b want 0111", col_n); end
    wait_cyc(40);
    checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL op_count: pulses %0d want 1", pulses - p0); end
    checks++; if (last_cyc !== 24) begin errors++; $display("FAIL op_cycle: got %0d want 24", last_cyc); end
    checks++; if (last_code !== 5'b10011) begin errors++; $display("FAIL op_code: got %b want 10011", last_code); end
    checks++; if (keycode !== 5'b10011) begin errors++; $display("FAIL op_hold_code: got %b want 10011", keycode); end
  endtask

  task automatic test_bounce();
    int p0;
    keys = 20'h00020;
    do_reset();
    p0 = pulses;
    wait_cyc(7);
    @(posedge clock); #1 keys = '0;         // release from cycle 8
    wait_cyc(11);
    @(posedge clock); #1 keys = 20'h00020;  // stable from cycle 12
    wait_cyc(30);
    checks++; if (pulses - p0 !== 0) begin errors++; $display("FAIL bounce_glitch: pulses %0d want 0", pulses - p0); end
    wait_cyc(45);
    checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL bounce_count: pulses %0d want 1", pulses - p0); end
    checks++; if (last_cyc !== 36) begin errors++; $display("FAIL bounce_cycle: got %0d want 36", last_cyc); end
    checks++; if (last_code !== 5'b00101) begin errors++; $display("FAIL bounce_code: got %b want 00101", last_code); end
  endtask

  task automatic test_back_to_back();
    int p0;
    keys = 20'h00400;
    do_reset();
    p0 = pulses;
    wait_cyc(20);
    checks++; if (newkey !== 1'b1) begin errors++; $display("FAIL repress_first: newkey %b want 1", newkey); end
    @(posedge clock); #1 keys = '0;         // release from cycle 21
    wait_cyc(31);
    @(posedge clock); #1 keys = 20'h00400;  // re-press from cycle 32
    wait_cyc(50);
    checks++; if (pulses - p0 !== 2) begin errors++; $display("FAIL repress_count: pulses %0d want 2", pulses - p0); end
    checks++; if (last_cyc !== 44) begin errors++; $display("FAIL repress_cycle: got %0d want 44", last_cyc); end
    checks++; if (last_code !== 5'b01010) begin errors++; $display("FAIL repress_code: got %b want 01010", last_code); end

    // Release lasting only two samples must not re-arm.
    do_reset();
    p0 = pulses;
    wait_cyc(20);
    @(posedge clock); #1 keys = '0;         // release from cycle 21
    wait_cyc(27);
    @(posedge clock); #1 keys = 20'h00400;  // re-press from cycle 28
    wait_cyc(100);
    checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL short_release: pulses %0d want 1", pulses - p0); end
  endtask

  task automatic test_multikey();
    int p0;
    keys = 20'h01010;
    do_reset();
    p0 = pulses;
    wait_cyc(20);
    checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL multi_count: pulses %0d want 1", pulses - p0); end
    checks++; if (last_cyc !== 12) begin errors++; $display("FAIL multi_cycle: got %0d want 12", last_cyc); end
    checks++; if (last_code !== 5'b00100) begin errors++; $display("FAIL multi_code: got %b want 00100", last_code); end
  endtask

  task automatic test_reset_pulse();
    keys = 20'h00010;
    do_reset();
    wait_cyc(11);
    @(posedge clock); #1 reset = 1'b1;      // reset sampled at end of cycle 12
    @(negedge clock);
    checks++; if (newkey !== 1'b1) begin errors++; $display("FAIL rstpulse_high: newkey %b want 1", newkey); end
    checks++; if (keycode !== 5'b00100) begin errors++; $display("FAIL rstpulse_code: got %b want 00100", keycode); end
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    checks++; if (newkey !== 1'b0) begin errors++; $display("FAIL rstpulse_newkey: got %b want 0", newkey); end
    checks++; if (keycode !== 5'b00000) begin errors++; $display("FAIL rstpulse_keycode: got %b want 00000", keycode); end
    checks++; if (col_n !== 4'b1110) begin errors++; $display("FAIL rstpulse_col: got %b want 1110", col_n); end
  endtask

  task automatic test_reset_mid();
    int p0;
    keys = 20'h00001;
    do_reset();
    p0 = pulses;
    wait_cyc(8);                            // two matching samples taken
    do_reset();
    wait_cyc(0);
    checks++; if (col_n !== 4'b1110) begin errors++; $display("FAIL rstmid_col: got %b want 1110", col_n); end
    checks++; if (newkey !== 1'b0) begin errors++; $display("FAIL rstmid_newkey: got %b want 0", newkey); end
    checks++; if (keycode !== 5'b00000) begin errors++; $display("FAIL rstmid_keycode: got %b want 00000", keycode); end
    wait_cyc(11);
    checks++; if (pulses - p0 !== 0) begin errors++; $display("FAIL rstmid_early: pulses %0d want 0", pulses - p0); end
    wait_cyc(12);
    checks++; if (newkey !== 1'b1) begin errors++; $display("FAIL rstmid_c12: newkey %b want 1", newkey); end
    wait_cyc(20);
    checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL rstmid_count: pulses %0d want 1", pulses - p0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_operator();
    test_bounce();
    test_back_to_back();
    test_multikey();
    test_reset_pulse();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
